// File: rtl/regfile_write_arbiter.sv
// Single register-file write port shared by MEM/WB writeback and photon-accelerator writes.
// Core writes win; photon writes queue in a small FIFO and retire in idle cycles, with a
// starvation counter that forces a drain (stalling the core) after too many losses.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic        core_we,
  input  logic [4:0]  core_rd,
  input  logic [31:0] core_data,
  input  logic        mem_hold,
  output logic        core_stall,
  input  logic        photon_we,
  input  logic [4:0]  photon_rd,
  input  logic [31:0] photon_data,
  output logic        photon_ready,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  output logic        pend_rs1,
  output logic        pend_rs2,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {SelIdle, SelForce, SelCore, SelDrain, SelBypass} sel_e;

  logic [4:0]       ent_rd_q   [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [DEPTH-1:0] ent_valid_q, ent_valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    starve_q, starve_d;

  logic [AW-1:0] wr_idx, rd_idx;
  logic          empty, full, any_live, head_live, head_dead;
  logic          cv, photon_live, force_drain, push, pop;
  sel_e          sel;
  logic [4:0]    wr_rd;
  logic [31:0]   wr_data;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

  // Valid bits are cleared on pop, so unoccupied slots never look live.
  assign any_live  = |ent_valid_q;
  assign head_live = ~empty & ent_valid_q[rd_idx];
  assign head_dead = ~empty & ~ent_valid_q[rd_idx];

  assign cv           = core_we & ~mem_hold & (|core_rd);
  assign photon_ready = Rst_n & ~full;
  assign photon_live  = photon_we & photon_ready & (|photon_rd);
  assign force_drain  = (starve_q == CW'(STARVE_MAX)) & head_live;
  assign core_stall   = force_drain;

  // Pick this cycle's writer.
  always_comb begin
    sel = SelIdle;
    if (force_drain)                   sel = SelForce;
    else if (cv)                       sel = SelCore;
    else if (head_live)                sel = SelDrain;
    else if (!any_live && photon_live) sel = SelBypass;
  end

  // A dead head is discarded without a write; at most one pop per cycle.
  assign pop  = head_dead | (sel == SelForce) | (sel == SelDrain);
  assign push = photon_live & (sel != SelBypass);

  // Source mux for the registered write port.
  always_comb begin
    wr_rd   = '0;
    wr_data = '0;
    case (sel)
      SelForce, SelDrain: begin
        wr_rd   = ent_rd_q[rd_idx];
        wr_data = ent_data_q[rd_idx];
      end
      SelCore: begin
        wr_rd   = core_rd;
        wr_data = core_data;
      end
      SelBypass: begin
        wr_rd   = photon_rd;
        wr_data = photon_data;
      end
      default: ;
    endcase
  end

  // Next valid bits: core kill, then pop, then push so a same-cycle push stays live.
  always_comb begin
    ent_valid_d = ent_valid_q;
    if (sel == SelCore) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (ent_rd_q[i] == core_rd) ent_valid_d[i] = 1'b0;
      end
    end
    if (pop)  ent_valid_d[rd_idx] = 1'b0;
    if (push) ent_valid_d[wr_idx] = 1'b1;
  end

  // Pointer and starvation counter next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    starve_d = starve_q;
    if (sel == SelForce || sel == SelDrain || !any_live) begin
      starve_d = '0;
    end else if (sel == SelCore && head_live && starve_q != CW'(STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Hazard flags: any live queued entry, or a photon write being queued this cycle.
  always_comb begin
    pend_rs1 = push && (photon_rd == chk_rs1);
    pend_rs2 = push && (photon_rd == chk_rs2);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_valid_q[i] && ent_rd_q[i] == chk_rs1) pend_rs1 = 1'b1;
      if (ent_valid_q[i] && ent_rd_q[i] == chk_rs2) pend_rs2 = 1'b1;
    end
    pend_rs1 = pend_rs1 & (|chk_rs1);
    pend_rs2 = pend_rs2 & (|chk_rs2);
  end

  // FIFO control state.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ent_valid_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      starve_q    <= '0;
    end else begin
      ent_valid_q <= ent_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      starve_q    <= starve_d;
    end
  end

  // FIFO payload storage; qualified by valid bits so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd_q[wr_idx]   <= photon_rd;
      ent_data_q[wr_idx] <= photon_data;
    end
  end

  // Registered write port; address and data hold during idle cycles.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= (sel != SelIdle);
      if (sel != SelIdle) begin
        rf_rd    <= wr_rd;
        rf_wdata <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model of the arbitration rules.
module tb_regfile_write_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        core_we = 1'b0, mem_hold = 1'b0, photon_we = 1'b0;
  logic [4:0]  core_rd = '0, photon_rd = '0, chk_rs1 = '0, chk_rs2 = '0;
  logic [31:0] core_data = '0, photon_data = '0;
  logic        core_stall, photon_ready, pend_rs1, pend_rs2, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  int checks = 0;
  int failures = 0;

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .Rst_n(Rst_n),
    .core_we(core_we), .core_rd(core_rd), .core_data(core_data), .mem_hold(mem_hold),
    .core_stall(core_stall),
    .photon_we(photon_we), .photon_rd(photon_rd), .photon_data(photon_data),
    .photon_ready(photon_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .pend_rs1(pend_rs1), .pend_rs2(pend_rs2),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  // Model: queued photon writes in arrival order, starvation count, expected port value.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        valid;
  } ent_t;

  ent_t        mq[$];
  int          m_cnt = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;

  function automatic bit m_any_live();
    foreach (mq[i]) if (mq[i].valid) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_head_live();
    return (mq.size() > 0) && mq[0].valid;
  endfunction

  function automatic bit m_ready();
    return Rst_n && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_stall();
    return Rst_n && (m_cnt == STARVE_MAX) && m_head_live();
  endfunction

  function automatic bit m_cv();
    return core_we && !mem_hold && (core_rd != 0);
  endfunction

  function automatic bit m_bypass();
    return !m_cv() && !m_any_live() && photon_we && m_ready() && (photon_rd != 0);
  endfunction

  function automatic bit m_push();
    return photon_we && m_ready() && (photon_rd != 0) && !m_bypass();
  endfunction

  function automatic bit m_pend(input logic [4:0] chk);
    if (chk == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].valid && mq[i].rd == chk) return 1'b1;
    return m_push() && (photon_rd == chk);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit f, c, d, b, p, dead, live, hl;
    if (!Rst_n) begin
      mq.delete();
      m_cnt = 0; m_we = 1'b0; m_rd = '0; m_data = '0;
      return;
    end
    live = m_any_live();
    hl   = m_head_live();
    f    = m_stall();
    c    = !f && m_cv();
    d    = !f && !c && hl;
    b    = m_bypass();
    p    = m_push();
    dead = (mq.size() > 0) && !mq[0].valid;
    m_we = f || c || d || b;
    if (f || d) begin
      m_rd = mq[0].rd; m_data = mq[0].data;
    end else if (c) begin
      m_rd = core_rd; m_data = core_data;
    end else if (b) begin
      m_rd = photon_rd; m_data = photon_data;
    end
    if (f || d || !live) m_cnt = 0;
    else if (c && hl && m_cnt < STARVE_MAX) m_cnt++;
    if (c) foreach (mq[i]) if (mq[i].rd == core_rd) mq[i].valid = 1'b0;
    if (f || d || dead) void'(mq.pop_front());
    if (p) mq.push_back({photon_rd, photon_data, 1'b1});
  endtask

  task automatic drive(input bit cwe, input logic [4:0] crd, input logic [31:0] cdat,
                       input bit hold, input bit pwe, input logic [4:0] prd,
                       input logic [31:0] pdat);
    core_we = cwe; core_rd = crd; core_data = cdat; mem_hold = hold;
    photon_we = pwe; photon_rd = prd; photon_data = pdat;
    #1;
  endtask

  // One clock: model follows the edge, return at the following negedge.
  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    Rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_step();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
    checks++; if (rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin failures++;
      $display("FAIL reset_rf_addr_data got=%0d/%0h exp=0/0", rf_rd, rf_wdata); end
    checks++; if (photon_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low got=%0b exp=0", photon_ready); end
    checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", core_stall); end
    Rst_n = 1'b1;
    chk_rs1 = 5'd7; chk_rs2 = 5'd8;
    #1;
    checks++; if (photon_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_high got=%0b exp=1", photon_ready); end
    @(negedge clk);
    // Queue two photon writes behind core traffic, then reset mid-stream.
    drive(1, 3, 32'h1, 0, 1, 7, 32'h11); tick();
    drive(1, 3, 32'h2, 0, 1, 8, 32'h22); tick();
    #2;
    Rst_n = 1'b0;
    #1;
    model_step();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL midreset_rf_we got=%0b exp=0", rf_we); end
    checks++; if (photon_ready !== 1'b0) begin failures++; $display("FAIL midreset_ready got=%0b exp=0", photon_ready); end
    @(negedge clk);
    Rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (photon_ready !== 1'b1) begin failures++; $display("FAIL postreset_ready got=%0b exp=1", photon_ready); end
    checks++; if (pend_rs1 !== 1'b0 || pend_rs2 !== 1'b0) begin failures++;
      $display("FAIL postreset_pend got=%0b%0b exp=00", pend_rs1, pend_rs2); end
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL postreset_no_write got=%0b exp=0", rf_we); end
  endtask

  task automatic test_bypass();
    chk_rs1 = 5'd5;
    drive(0, 0, 0, 0, 1, 5, 32'hA5A5A5A5);
    checks++; if (pend_rs1 !== 1'b0) begin failures++; $display("FAIL bypass_pend got=%0b exp=0", pend_rs1); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hA5A5A5A5) begin failures++;
      $display("FAIL bypass_write got=%0b/%0d/%0h exp=1/5/a5a5a5a5", rf_we, rf_rd, rf_wdata); end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL bypass_fifo_empty got=%0b exp=0", rf_we); end
  endtask

  task automatic test_priority();
    chk_rs1 = 5'd7; chk_rs2 = 5'd8;
    drive(1, 3, 32'h1, 0, 1, 7, 32'h11);
    checks++; if (pend_rs1 !== 1'b1) begin failures++; $display("FAIL prio_pend_push got=%0b exp=1", pend_rs1); end
    tick();
    drive(1, 3, 32'h1, 0, 1, 8, 32'h22);
    checks++; if (pend_rs1 !== 1'b1 || pend_rs2 !== 1'b1) begin failures++;
      $display("FAIL prio_pend_both got=%0b%0b exp=11", pend_rs1, pend_rs2); end
    tick();
    drive(1, 3, 32'h1, 0, 0, 0, 0);
    tick();
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h1) begin failures++;
      $display("FAIL prio_core_wins got=%0b/%0d/%0h exp=1/3/1", rf_we, rf_rd, rf_wdata); end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h11) begin failures++;
      $display("FAIL prio_drain_x7 got=%0b/%0d/%0h exp=1/7/11", rf_we, rf_rd, rf_wdata); end
    checks++; if (pend_rs1 !== 1'b0) begin failures++; $display("FAIL prio_pend_cleared got=%0b exp=0", pend_rs1); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd8 || rf_wdata !== 32'h22) begin failures++;
      $display("FAIL prio_drain_x8 got=%0b/%0d/%0h exp=1/8/22", rf_we, rf_rd, rf_wdata); end
    tick();
    checks++; if (rf_we !== 1'b0 || rf_rd !== 5'd8) begin failures++;
      $display("FAIL prio_idle_hold got=%0b/%0d exp=0/8", rf_we, rf_rd); end
  endtask

  task automatic test_kill();
    chk_rs1 = 5'd9;
    drive(1, 3, 32'h1, 0, 1, 9, 32'hDEAD);
    tick();
    drive(1, 9, 32'hBEEF, 0, 0, 0, 0);
    checks++; if (pend_rs1 !== 1'b1) begin failures++; $display("FAIL kill_pend_before got=%0b exp=1", pend_rs1); end
    tick();
    checks++; if (rf_rd !== 5'd9 || rf_wdata !== 32'hBEEF) begin failures++;
      $display("FAIL kill_core_write got=%0d/%0h exp=9/beef", rf_rd, rf_wdata); end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (pend_rs1 !== 1'b0) begin failures++; $display("FAIL kill_pend_drop got=%0b exp=0", pend_rs1); end
    tick();
    checks++; if (rf_we !== 1'b0 || rf_wdata !== 32'hBEEF) begin failures++;
      $display("FAIL kill_silent_pop got=%0b/%0h exp=0/beef", rf_we, rf_wdata); end
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL kill_no_late_write got=%0b exp=0", rf_we); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] exp_q[$];
    logic [31:0] e;
    bit          acc;
    int          k = 0;
    int          guard = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, i, 0, 1, 5'(10 + i), 32'h100 + i);
      checks++; if (photon_ready !== 1'b1) begin failures++; $display("FAIL full_ready_%0d got=%0b exp=1", i, photon_ready); end
      exp_q.push_back(32'h100 + i);
      tick();
    end
    drive(1, 3, 32'h9, 0, 1, 14, 32'h104);
    checks++; if (photon_ready !== 1'b0) begin failures++; $display("FAIL full_ready_low got=%0b exp=0", photon_ready); end
    tick();
    checks++; if (rf_rd !== 5'd3 || rf_wdata !== 32'h9) begin failures++;
      $display("FAIL full_core_during got=%0d/%0h exp=3/9", rf_rd, rf_wdata); end
    // Drain while offering 9 more writes; everything must retire in arrival order.
    while ((exp_q.size() > 0 || k < 9) && guard < 60) begin
      guard++;
      if (k < 9) drive(0, 0, 0, 0, 1, 5'(14 + k), 32'h104 + k);
      else       drive(0, 0, 0, 0, 0, 0, 0);
      acc = m_ready();
      checks++; if (photon_ready !== acc) begin failures++;
        $display("FAIL wrap_ready got=%0b exp=%0b", photon_ready, acc); end
      if (k < 9 && acc) begin
        exp_q.push_back(32'h104 + k);
        k++;
      end
      tick();
      if (rf_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL wrap_extra_write got=%0h exp=none", rf_wdata);
        end else begin
          e = exp_q.pop_front();
          if (rf_wdata !== e) begin failures++; $display("FAIL wrap_order got=%0h exp=%0h", rf_wdata, e); end
        end
      end
    end
    checks++; if (guard >= 60) begin failures++; $display("FAIL wrap_timeout got=%0d left exp=0", exp_q.size()); end
  endtask

  task automatic test_starve();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    drive(1, 3, 32'h30, 0, 1, 20, 32'h77);
    tick();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 3, 32'h30 + i, 0, 0, 0, 0);
      checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL starve_early_stall_%0d got=1 exp=0", i); end
      tick();
      checks++; if (rf_rd !== 5'd3 || rf_wdata !== 32'h30 + i) begin failures++;
        $display("FAIL starve_loss_%0d got=%0d/%0h exp=3/%0h", i, rf_rd, rf_wdata, 32'h30 + i); end
    end
    drive(1, 4, 32'h44, 0, 0, 0, 0);
    checks++; if (core_stall !== 1'b1) begin failures++; $display("FAIL starve_stall got=%0b exp=1", core_stall); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd20 || rf_wdata !== 32'h77) begin failures++;
      $display("FAIL starve_forced got=%0b/%0d/%0h exp=1/20/77", rf_we, rf_rd, rf_wdata); end
    checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL starve_stall_once got=%0b exp=0", core_stall); end
    tick();
    checks++; if (rf_rd !== 5'd4 || rf_wdata !== 32'h44) begin failures++;
      $display("FAIL starve_core_retire got=%0d/%0h exp=4/44", rf_rd, rf_wdata); end
    drive(1, 5, 32'h55, 1, 0, 0, 0);
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL starve_mem_hold got=%0b exp=0", rf_we); end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    bit prev_stall = 1'b0;
    int pct;
    for (int n = 0; n < 600; n++) begin
      pct = (n < 300) ? 92 : 50;
      if (!prev_stall) begin
        core_we   = ($urandom_range(0, 99) < pct);
        core_rd   = 5'($urandom_range(0, 7));
        core_data = $urandom;
        mem_hold  = ($urandom_range(0, 9) == 0);
      end
      photon_we   = ($urandom_range(0, 99) < 45);
      photon_rd   = 5'($urandom_range(0, 7));
      photon_data = $urandom;
      chk_rs1     = 5'($urandom_range(0, 7));
      chk_rs2     = 5'($urandom_range(0, 7));
      #1;
      checks++; if (core_stall !== m_stall()) begin failures++;
        $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, core_stall, m_stall()); end
      checks++; if (photon_ready !== m_ready()) begin failures++;
        $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, photon_ready, m_ready()); end
      checks++; if (pend_rs1 !== m_pend(chk_rs1) || pend_rs2 !== m_pend(chk_rs2)) begin failures++;
        $display("FAIL rnd_pend n=%0d got=%0b%0b exp=%0b%0b", n, pend_rs1, pend_rs2,
                 m_pend(chk_rs1), m_pend(chk_rs2)); end
      prev_stall = m_stall();
      tick();
      checks++; if (rf_we !== m_we || rf_rd !== m_rd || rf_wdata !== m_data) begin failures++;
        $display("FAIL rnd_port n=%0d got=%0b/%0d/%0h exp=%0b/%0d/%0h", n, rf_we, rf_rd, rf_wdata,
                 m_we, m_rd, m_data); end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_priority();
    test_kill();
    test_full_wrap();
    test_starve();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
